// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, ALU
// operation encodings, FSM state codes and the decode result bundle.
package reg_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_SUBI = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       is_jmp;
    logic       is_halt;
    logic       is_illegal;
  } dec_t;

endpackage

// File: rtl/reg_seq_ctrl_if.sv
// Bundle between the sequencer, the instruction ROM, the register file/ALU
// pair and the start/done control side. The master modport is the sequencer.
// Handshake: start is a level sampled only while busy=0; one sampled start
// launches one program run, which ends with a single-cycle done pulse.
interface reg_seq_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               start;
  logic [ADDR_W-1:0]  start_addr;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_rdata;
  logic [11:0]        instruction;
  logic               Reg_Write;
  logic               ALU_Src;
  logic               Reg_Store;
  logic [1:0]         alu_op;
  logic               Overflow;
  logic               busy;
  logic               done;
  logic               ovf_flag;
  logic               illegal;

  modport master (
    input  start, start_addr, rom_rdata, Overflow,
    output rom_addr, instruction, Reg_Write, ALU_Src, Reg_Store, alu_op,
           busy, done, ovf_flag, illegal
  );

  modport slave (
    output start, start_addr, rom_rdata, Overflow,
    input  rom_addr, instruction, Reg_Write, ALU_Src, Reg_Store, alu_op,
           busy, done, ovf_flag, illegal
  );
endinterface

// File: rtl/reg_seq_decode.sv
// Pure combinational opcode decoder. Opcodes 8..E are not defined and are
// flagged illegal; they produce no register write and behave as NOP.
module reg_seq_decode
  import reg_seq_pkg::*;
(
  input  logic [3:0] opcode_i,
  output dec_t       dec_o
);

  // Map each opcode to its control bundle; everything defaults to a NOP.
  always_comb begin
    dec_o = '0;
    unique case (opcode_i)
      OP_NOP:  ;
      OP_ADD:  begin dec_o.reg_write = 1'b1; dec_o.alu_op = ALU_ADD; end
      OP_SUB:  begin dec_o.reg_write = 1'b1; dec_o.alu_op = ALU_SUB; end
      OP_AND:  begin dec_o.reg_write = 1'b1; dec_o.alu_op = ALU_AND; end
      OP_OR:   begin dec_o.reg_write = 1'b1; dec_o.alu_op = ALU_OR;  end
      OP_ADDI: begin
        dec_o.reg_write = 1'b1;
        dec_o.alu_src   = 1'b1;
        dec_o.alu_op    = ALU_ADD;
      end
      OP_SUBI: begin
        dec_o.reg_write = 1'b1;
        dec_o.alu_src   = 1'b1;
        dec_o.alu_op    = ALU_SUB;
      end
      OP_JMP:  dec_o.is_jmp  = 1'b1;
      OP_HALT: dec_o.is_halt = 1'b1;
      default: dec_o.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_seq_ctrl.sv
// Multi-cycle sequencer: FETCH presents pc to the ROM, LOAD captures the
// word, READ lets the register file sample operands, WB strobes the write
// and advances pc. Four cycles per instruction; HALT returns to IDLE.
// ADDR_W/INSTR_W must match the parameters of the connected interface.
module reg_seq_ctrl
  import reg_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_seq_ctrl_if.master       bus,
  output logic [2:0]           dbg_state_o
);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               ovf_q, ovf_d;
  logic               ill_q, ill_d;
  dec_t               dec;
  logic               in_wb;

  reg_seq_decode u_decode (
    .opcode_i (instr_q[15:12]),
    .dec_o    (dec)
  );

  // Next-state logic for the FSM, program counter, instruction and stickies.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pc_d    = bus.start_addr;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        instr_d = bus.rom_rdata;
        state_d = ST_READ;
      end
      ST_READ:  state_d = ST_WB;
      ST_WB: begin
        if (dec.reg_write && bus.Overflow) ovf_d = 1'b1;
        if (dec.is_illegal)                ill_d = 1'b1;
        if (dec.is_halt) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
          pc_d    = dec.is_jmp ? ADDR_W'(instr_q[7:0]) : pc_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  // Write strobe and done are qualified by rst_n so an aborted WB commits nothing.
  assign in_wb = (state_q == ST_WB) && rst_n;

  assign bus.rom_addr    = pc_q;
  assign bus.instruction = instr_q[11:0];
  assign bus.Reg_Write   = dec.reg_write;
  assign bus.ALU_Src     = dec.alu_src;
  assign bus.alu_op      = dec.alu_op;
  assign bus.Reg_Store   = in_wb;
  assign bus.done        = in_wb && dec.is_halt;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.ovf_flag    = ovf_q;
  assign bus.illegal     = ill_q;
  assign dbg_state_o     = state_q;

endmodule
